// File: rtl/axi_axis2bram_wc.sv
// Width-converting AXI4-Stream sink: splits each accepted beat into RATIO BRAM words,
// writes them from a latched base address and ends on the word depth or on tlast.
module axi_axis2bram_wc #(
    parameter int AXI_DATA_WIDTH      = 512,
    parameter int BRAM_DATA_WIDTH     = 128,
    parameter int BRAM_ADDR_WIDTH     = 32,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int BRAM_DELAY          = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_size_bytes,
    output logic                           o_done,
    output logic                           o_done_pulse,
    output logic                           o_err_short,
    output logic [BRAM_ADDR_WIDTH:0]       o_words_written,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [AXI_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic                           o_wren,
    output logic [BRAM_ADDR_WIDTH-1:0]     o_wraddr,
    output logic [BRAM_DATA_WIDTH-1:0]     o_wrdata
);
    localparam int RATIO = AXI_DATA_WIDTH / BRAM_DATA_WIDTH;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DW    = BRAM_ADDR_WIDTH + 1;
    localparam int CW    = $clog2(BRAM_DELAY + 1);
    localparam int BW    = AXI_XFER_SIZE_WIDTH + 4;

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
    state_t state, state_nxt;

    logic [BRAM_ADDR_WIDTH-1:0]            base_q;
    logic [DW-1:0]                         depth_q, idx_q, depth_in;
    logic [RATIO-1:0][BRAM_DATA_WIDTH-1:0] hold_q;
    logic                                  hold_full, hold_last;
    logic [SW-1:0]                         slice_q;
    logic [CW-1:0]                         flush_cnt;
    logic [BW-1:0]                         bits_up;
    logic [BRAM_DATA_WIDTH-1:0]            slice_data;
    logic issue, last_slice, reach_depth, beat_done, fin, hs;

    // Round the bit count up to whole BRAM words before truncating to the counter width
    assign bits_up  = {1'b0, i_size_bytes, 3'b000} + BW'(BRAM_DATA_WIDTH - 1);
    assign depth_in = DW'(bits_up / BW'(BRAM_DATA_WIDTH));

    generate
        if (RATIO == 1) begin : g_one
            assign slice_data = hold_q[0];
        end else begin : g_mux
            assign slice_data = hold_q[slice_q];
        end
    endgenerate

    assign issue       = (state == BUSY) && hold_full && i_ready;
    assign last_slice  = issue && (slice_q == SW'(RATIO - 1));
    assign reach_depth = issue && (idx_q + DW'(1) == depth_q);
    assign beat_done   = last_slice || reach_depth;
    assign fin         = reach_depth || (last_slice && hold_last);
    assign hs          = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (depth_in == '0) ? FLUSH : BUSY;
            BUSY:    if (fin) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == CW'(BRAM_DELAY - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A new beat may enter while the last slice of the current one issues,
    // unless that slice also ends the transfer.
    always_comb begin
        o_done        = (state == IDLE);
        s_axis_tready = (state == BUSY) && i_ready && (!hold_full || (beat_done && !fin));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            depth_q         <= '0;
            idx_q           <= '0;
            hold_q          <= '0;
            hold_full       <= 1'b0;
            hold_last       <= 1'b0;
            slice_q         <= '0;
            flush_cnt       <= '0;
            o_done_pulse    <= 1'b0;
            o_err_short     <= 1'b0;
            o_words_written <= '0;
            o_wren          <= 1'b0;
            o_wraddr        <= '0;
            o_wrdata        <= '0;
        end else begin
            o_done_pulse <= (state == FLUSH) && (state_nxt == IDLE);
            flush_cnt    <= (state == FLUSH) ? flush_cnt + CW'(1) : '0;
            o_wren       <= issue;
            if (issue) begin
                o_wraddr <= base_q + idx_q[BRAM_ADDR_WIDTH-1:0];
                o_wrdata <= slice_data;
                idx_q    <= idx_q + DW'(1);
            end
            if (hs) begin
                hold_q    <= s_axis_tdata;
                hold_full <= 1'b1;
                hold_last <= s_axis_tlast;
                slice_q   <= '0;
            end else if (beat_done) begin
                hold_full <= 1'b0;
                slice_q   <= '0;
            end else if (issue) begin
                slice_q <= slice_q + SW'(1);
            end
            if (last_slice && hold_last && !reach_depth) o_err_short <= 1'b1;
            if (o_wren && (o_words_written < depth_q)) o_words_written <= o_words_written + DW'(1);
            if (state == IDLE && i_start) begin
                base_q          <= i_base_addr;
                depth_q         <= depth_in;
                idx_q           <= '0;
                hold_full       <= 1'b0;
                slice_q         <= '0;
                o_err_short     <= 1'b0;
                o_words_written <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axi_axis2bram_wc.sv
// Bench for axi_axis2bram_wc: three instances (RATIO 4, 1, 2) driven from one
// stimulus process, with a write scoreboard filled as beats are offered.
module tb_axi_axis2bram_wc;
    typedef struct {
        int           d;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b1, rdy = 1'b1, tog = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [31:0]  base = '0, size = '0;
    logic         tvalid = 1'b0, tlast = 1'b0;
    logic [511:0] tdata = '0;

    logic         done_a, dp_a, err_a, tr_a, wren_a;
    logic         done_b, dp_b, err_b, tr_b, wren_b;
    logic         done_c, dp_c, err_c, tr_c, wren_c;
    logic [32:0]  words_a, words_b, words_c;
    logic [31:0]  wa_a, wa_b, wa_c;
    logic [127:0] wd_a;
    logic [63:0]  wd_b, wd_c;

    logic         done_v[3], dp[3], err_v[3], trdy[3], wr_en[3];
    logic [32:0]  words[3];
    logic [31:0]  wr_addr[3];
    logic [127:0] wr_dat[3];

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0;
    int   last_wr[3], pulse_cyc[3];

    always #5 clk = ~clk;

    axi_axis2bram_wc #(.AXI_DATA_WIDTH(512), .BRAM_DATA_WIDTH(128)) u_r4 (
        .clk(clk), .rst(rst), .i_start(start_a), .i_ready(rdy), .i_base_addr(base),
        .i_size_bytes(size), .o_done(done_a), .o_done_pulse(dp_a), .o_err_short(err_a),
        .o_words_written(words_a), .s_axis_tvalid(tvalid), .s_axis_tready(tr_a),
        .s_axis_tdata(tdata), .s_axis_tlast(tlast), .o_wren(wren_a), .o_wraddr(wa_a), .o_wrdata(wd_a));

    axi_axis2bram_wc #(.AXI_DATA_WIDTH(64), .BRAM_DATA_WIDTH(64)) u_r1 (
        .clk(clk), .rst(rst), .i_start(start_b), .i_ready(rdy), .i_base_addr(base),
        .i_size_bytes(size), .o_done(done_b), .o_done_pulse(dp_b), .o_err_short(err_b),
        .o_words_written(words_b), .s_axis_tvalid(tvalid), .s_axis_tready(tr_b),
        .s_axis_tdata(tdata[63:0]), .s_axis_tlast(tlast), .o_wren(wren_b), .o_wraddr(wa_b), .o_wrdata(wd_b));

    axi_axis2bram_wc #(.AXI_DATA_WIDTH(128), .BRAM_DATA_WIDTH(64)) u_r2 (
        .clk(clk), .rst(rst), .i_start(start_c), .i_ready(rdy), .i_base_addr(base),
        .i_size_bytes(size), .o_done(done_c), .o_done_pulse(dp_c), .o_err_short(err_c),
        .o_words_written(words_c), .s_axis_tvalid(tvalid), .s_axis_tready(tr_c),
        .s_axis_tdata(tdata[127:0]), .s_axis_tlast(tlast), .o_wren(wren_c), .o_wraddr(wa_c), .o_wrdata(wd_c));

    always_comb begin
        done_v[0] = done_a; dp[0] = dp_a; err_v[0] = err_a; trdy[0] = tr_a; wr_en[0] = wren_a;
        done_v[1] = done_b; dp[1] = dp_b; err_v[1] = err_b; trdy[1] = tr_b; wr_en[1] = wren_b;
        done_v[2] = done_c; dp[2] = dp_c; err_v[2] = err_c; trdy[2] = tr_c; wr_en[2] = wren_c;
        words[0] = words_a; words[1] = words_b; words[2] = words_c;
        wr_addr[0] = wa_a; wr_addr[1] = wa_b; wr_addr[2] = wa_c;
        wr_dat[0] = wd_a; wr_dat[1] = {64'b0, wd_b}; wr_dat[2] = {64'b0, wd_c};
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Advance one cycle (sampling at the falling edge) and score any BRAM write
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tog) rdy = ~rdy;
        for (int d = 0; d < 3; d++) begin
            if (dp[d]) pulse_cyc[d] = cyc;
            if (wr_en[d]) begin
                last_wr[d] = cyc;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected dut=%0d got addr=%h data=%h, expected no write", d, wr_addr[d], wr_dat[d]);
                end else begin
                    e = q.pop_front();
                    if (e.d !== d || e.addr !== wr_addr[d] || e.data !== wr_dat[d]) begin
                        failures++;
                        $display("FAIL wr_match dut=%0d got addr=%h data=%h, expected dut=%0d addr=%h data=%h",
                                 d, wr_addr[d], wr_dat[d], e.d, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic push_beat(input int d, input logic [511:0] data, input int bw,
                             input logic [31:0] addr0, input int n);
        exp_t e;
        logic [127:0] s;
        for (int k = 0; k < n; k++) begin
            s = 128'(data >> (k * bw));
            if (bw == 64) s[127:64] = '0;
            e.d = d; e.addr = addr0 + 32'(k); e.data = s;
            q.push_back(e);
        end
    endtask

    task automatic do_start(input int d, input logic [31:0] b, input logic [31:0] sz);
        base = b; size = sz;
        pulse_cyc[d] = -1;
        if (d == 0) start_a = 1'b1; else if (d == 1) start_b = 1'b1; else start_c = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic send(input int d, input logic [511:0] data, input logic last);
        logic got;
        int   n;
        tvalid = 1'b1; tdata = data; tlast = last;
        got = 1'b0;
        for (n = 0; n < 100 && !got; n++) begin
            #1 got = trdy[d];
            step();
        end
        tvalid = 1'b0; tlast = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_timeout dut=%0d got no handshake, expected tready within 100 cycles", d);
        end
    endtask

    task automatic wait_done(input int d);
        for (int n = 0; n < 100 && pulse_cyc[d] < 0; n++) step();
        checks++;
        if (pulse_cyc[d] < 0 || done_v[d] !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout dut=%0d got done=%b pulse_cyc=%0d, expected done pulse", d, done_v[d], pulse_cyc[d]);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (done_v[d] !== 1'b1 || dp[d] !== 1'b0 || err_v[d] !== 1'b0 || trdy[d] !== 1'b0 ||
                wr_en[d] !== 1'b0 || words[d] !== 33'd0 || wr_addr[d] !== 32'd0 || wr_dat[d] !== 128'd0) begin
                failures++;
                $display("FAIL reset_state dut=%0d got done=%b dp=%b err=%b trdy=%b wren=%b words=%0d addr=%h, expected 1,0,0,0,0,0,0",
                         d, done_v[d], dp[d], err_v[d], trdy[d], wr_en[d], words[d], wr_addr[d]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ratio4();
        logic [511:0] b0, b1;
        b0 = rnd512(); b1 = rnd512();
        push_beat(0, b0, 128, 32'h100, 4);
        push_beat(0, b1, 128, 32'h104, 4);
        do_start(0, 32'h100, 32'd128);
        checks++;
        if (done_a !== 1'b0) begin failures++; $display("FAIL busy_done got %b expected 0", done_a); end
        send(0, b0, 1'b0);
        send(0, b1, 1'b1);
        wait_done(0);
        checks++;
        if (words_a !== 33'd8 || err_a !== 1'b0 || pulse_cyc[0] - last_wr[0] != 2) begin
            failures++;
            $display("FAIL t1_end got words=%0d err=%b pulse_gap=%0d, expected 8,0,2", words_a, err_a, pulse_cyc[0] - last_wr[0]);
        end
    endtask

    task automatic test_truncate();
        logic [511:0] b0;
        b0 = rnd512();
        push_beat(0, b0, 128, 32'h0, 3);
        do_start(0, 32'h0, 32'd40);
        send(0, b0, 1'b0);
        tvalid = 1'b1; tdata = rnd512();
        for (int i = 0; i < 6; i++) begin
            #1 checks++;
            if (tr_a !== 1'b0) begin failures++; $display("FAIL t2_tready cycle=%0d got %b expected 0", i, tr_a); end
            step();
        end
        tvalid = 1'b0;
        wait_done(0);
        checks++;
        if (words_a !== 33'd3 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL t2_end got words=%0d err=%b, expected 3,0", words_a, err_a);
        end
    endtask

    task automatic test_short();
        logic [511:0] b0, b1;
        b0 = rnd512(); b1 = rnd512();
        push_beat(1, b0, 64, 32'h40, 1);
        push_beat(1, b1, 64, 32'h41, 1);
        do_start(1, 32'h40, 32'd256);
        send(1, b0, 1'b0);
        send(1, b1, 1'b1);
        wait_done(1);
        checks++;
        if (words_b !== 33'd2 || err_b !== 1'b1) begin
            failures++;
            $display("FAIL t3_short got words=%0d err=%b, expected 2,1", words_b, err_b);
        end
    endtask

    task automatic test_ready_toggle();
        logic [511:0] b;
        do_start(2, 32'h200, 32'd64);
        tog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = rnd512();
            push_beat(2, b, 64, 32'h200 + 32'(2 * i), 2);
            send(2, b, i == 3);
        end
        wait_done(2);
        tog = 1'b0; rdy = 1'b1;
        checks++;
        if (words_c !== 33'd8 || err_c !== 1'b0) begin
            failures++;
            $display("FAIL t4_end got words=%0d err=%b, expected 8,0", words_c, err_c);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] b0, b1;
        b0 = rnd512(); b1 = rnd512();
        push_beat(1, b0, 64, 32'h80, 1);
        push_beat(1, b1, 64, 32'h81, 1);
        do_start(1, 32'h80, 32'd16);
        checks++;
        if (err_b !== 1'b0 || words_b !== 33'd0) begin
            failures++;
            $display("FAIL err_clear got err=%b words=%0d, expected 0,0", err_b, words_b);
        end
        send(1, b0, 1'b0);
        send(1, b1, 1'b1);
        wait_done(1);
        checks++;
        if (words_b !== 33'd2 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got words=%0d err=%b, expected 2,0", words_b, err_b);
        end
    endtask

    task automatic test_zero_and_abort();
        int s;
        do_start(0, 32'h300, 32'd0);
        s = cyc;
        tvalid = 1'b1; tdata = rnd512();
        for (int i = 0; i < 4; i++) begin
            #1 checks++;
            if (tr_a !== 1'b0) begin failures++; $display("FAIL t5_tready cycle=%0d got %b expected 0", i, tr_a); end
            step();
        end
        tvalid = 1'b0;
        checks++;
        if (pulse_cyc[0] - s != 2 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL t5_pulse got gap=%0d done=%b, expected 2,1", pulse_cyc[0] - s, done_a);
        end
        do_start(0, 32'h0, 32'd128);
        send(0, rnd512(), 1'b0);
        rst = 1'b1;
        #1 checks++;
        if (wren_a !== 1'b0 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_now got wren=%b done=%b, expected 0,1", wren_a, done_a);
        end
        step();
        checks++;
        if (wren_a !== 1'b0 || done_a !== 1'b1 || tr_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_next got wren=%b done=%b trdy=%b, expected 0,1,0", wren_a, done_a, tr_a);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        logic [511:0] b0;
        b0 = rnd512();
        push_beat(0, b0, 128, 32'hFFFF_FFFE, 4);
        do_start(0, 32'hFFFF_FFFE, 32'd64);
        base = 32'h500; size = 32'd16; start_a = 1'b1;
        step();
        start_a = 1'b0;
        send(0, b0, 1'b1);
        wait_done(0);
        checks++;
        if (words_a !== 33'd4 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL t6_end got words=%0d err=%b, expected 4,0", words_a, err_a);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin last_wr[d] = 0; pulse_cyc[d] = -1; end
        test_reset();
        test_ratio4();
        test_truncate();
        test_short();
        test_ready_toggle();
        test_back_to_back();
        test_zero_and_abort();
        test_wrap();
        repeat (4) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got %0d pending writes, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
